bram_sp_ram_be: RTL and testbench

//   Parametrised single-port block RAM with per-byte write enables, selectable

---
 rtl/bram_sp_ram_be.sv | 156 +++++++++++++++
 tb/tb_bram_sp_ram_be.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sp_ram_be.sv
// Single-port block RAM with byte enables, read-during-write modes,
// an optional output register and a post-reset clear sequencer.
module bram_sp_ram_be #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_a,
  input  logic [DATA_WIDTH/8-1:0] we_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   din_a,
  output logic [DATA_WIDTH-1:0]   dout_a,
  output logic                    dvalid_a,
  output logic                    busy_a
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    busy;
  logic                    clr_we;
  logic                    acc;
  logic                    is_wr;
  logic [DATA_WIDTH-1:0]   old_w;
  logic [DATA_WIDTH-1:0]   merged_w;

  logic [DATA_WIDTH-1:0]   s1_q, s1_d;
  logic                    v1_q, v1_d;
  logic [DATA_WIDTH-1:0]   s2_q;
  logic                    v2_q;

  // State and clear-address register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Walk the clear address; leave CLEAR after the last word.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        state_d = S_READY;
      end
      default: begin
        state_d = S_READY;
      end
    endcase
  end

  // Decode the FSM into array controls and user-access qualification.
  always_comb begin
    busy   = (state_q == S_CLEAR);
    clr_we = busy;
    acc    = en_a & ~busy;
    is_wr  = |we_a;
  end

  // Old word and byte-merged word at the user address.
  always_comb begin
    old_w    = mem[addr_a];
    merged_w = old_w;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (we_a[i]) begin
        merged_w[8*i +: 8] = din_a[8*i +: 8];
      end
    end
  end

  // Array write port: clear sequencer has priority over user lanes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_we) begin
        mem[clr_cnt_q] <= '0;
      end else if (acc) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (we_a[i]) begin
            mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
          end
        end
      end
    end
  end

  // First read stage, including read-during-write selection.
  always_comb begin
    s1_d = s1_q;
    v1_d = 1'b0;
    if (acc) begin
      if (!is_wr) begin
        s1_d = old_w;
        v1_d = 1'b1;
      end else if (RDW_MODE == 1) begin
        s1_d = old_w;
        v1_d = 1'b1;
      end else if (RDW_MODE == 2) begin
        s1_d = merged_w;
        v1_d = 1'b1;
      end
    end
  end

  // Stage-1 registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      v1_q <= v1_d;
    end
  end

  // Optional stage-2 registers; hold data when nothing new arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_q <= '0;
      v2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        s2_q <= s1_q;
      end
    end
  end

  assign dout_a   = (OUT_REG != 0) ? s2_q : s1_q;
  assign dvalid_a = (OUT_REG != 0) ? v2_q : v1_q;
  assign busy_a   = busy;

endmodule

// File: tb/tb_bram_sp_ram_be.sv
// Bench for bram_sp_ram_be: three parameter variants driven in
// lockstep and compared against a word-array reference model.
module tb_bram_sp_ram_be;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a = 1'b0;
  logic [3:0]  we_a = '0;
  logic [9:0]  addr_a = '0;
  logic [31:0] din_a = '0;

  logic [31:0] dout0, dout1, dout2;
  logic        dv0, dv1, dv2;
  logic        busy0, busy1, busy2;

  always #5 clk = ~clk;

  bram_sp_ram_be #(.RDW_MODE(0), .OUT_REG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .en_a(en_a), .we_a(we_a),
    .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout0), .dvalid_a(dv0), .busy_a(busy0)
  );

  bram_sp_ram_be #(.RDW_MODE(1), .OUT_REG(0)) u1 (
    .clk(clk), .rst_n(rst_n), .en_a(en_a), .we_a(we_a),
    .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout1), .dvalid_a(dv1), .busy_a(busy1)
  );

  bram_sp_ram_be #(.RDW_MODE(2), .OUT_REG(1)) u2 (
    .clk(clk), .rst_n(rst_n), .en_a(en_a), .we_a(we_a),
    .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout2), .dvalid_a(dv2), .busy_a(busy2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: plain word array plus per-variant output view.
  logic [31:0] mref [1024];
  int          clr_left = 0;
  int          mode [3] = '{0, 1, 2};
  int          lat  [3] = '{1, 1, 2};
  logic [31:0] exp_d  [3];
  bit          exp_v  [3];
  logic [31:0] pend_d [3];
  bit          pend_v [3];

  task automatic model_step(bit r, bit e, logic [3:0] w,
                            logic [9:0] a, logic [31:0] d);
    logic [31:0] old_w, mrg;
    bit          ok, rv;
    logic [31:0] rd;
    if (!r) begin
      clr_left = 1024;
      for (int i = 0; i < 1024; i++) mref[i] = '0;
      for (int k = 0; k < 3; k++) begin
        exp_d[k]  = '0;
        exp_v[k]  = 1'b0;
        pend_d[k] = '0;
        pend_v[k] = 1'b0;
      end
      return;
    end
    ok    = e && (clr_left == 0);
    old_w = mref[a];
    mrg   = old_w;
    for (int b = 0; b < 4; b++)
      if (w[b]) mrg[8*b +: 8] = d[8*b +: 8];
    for (int k = 0; k < 3; k++) begin
      rv = 1'b0;
      rd = '0;
      if (ok) begin
        if (w == 4'h0) begin
          rv = 1'b1; rd = old_w;
        end else if (mode[k] == 1) begin
          rv = 1'b1; rd = old_w;
        end else if (mode[k] == 2) begin
          rv = 1'b1; rd = mrg;
        end
      end
      if (lat[k] == 1) begin
        exp_v[k] = rv;
        if (rv) exp_d[k] = rd;
      end else begin
        exp_v[k] = pend_v[k];
        if (pend_v[k]) exp_d[k] = pend_d[k];
        pend_v[k] = rv;
        pend_d[k] = rd;
      end
    end
    if (ok && w != 4'h0) mref[a] = mrg;
    if (clr_left > 0) clr_left--;
  endtask

  task automatic check_outs();
    logic [31:0] eb;
    eb = (clr_left > 0) ? 32'd1 : 32'd0;
    chk("dout0", dout0, exp_d[0]);
    chk("dv0", {31'd0, dv0}, {31'd0, exp_v[0]});
    chk("dout1", dout1, exp_d[1]);
    chk("dv1", {31'd0, dv1}, {31'd0, exp_v[1]});
    chk("dout2", dout2, exp_d[2]);
    chk("dv2", {31'd0, dv2}, {31'd0, exp_v[2]});
    chk("busy0", {31'd0, busy0}, eb);
    chk("busy1", {31'd0, busy1}, eb);
    chk("busy2", {31'd0, busy2}, eb);
  endtask

  task automatic cyc(bit r, bit e, logic [3:0] w,
                     logic [9:0] a, logic [31:0] d);
    rst_n  = r;
    en_a   = e;
    we_a   = w;
    addr_a = a;
    din_a  = d;
    @(posedge clk);
    #1;
    model_step(r, e, w, a, d);
    check_outs();
  endtask

  task automatic count_busy(string tag);
    int cnt;
    cnt = 0;
    while (busy0 === 1'b1 && cnt < 2000) begin
      cnt++;
      cyc(1'b1, 1'b0, 4'h0, 10'd0, 32'd0);
    end
    chk(tag, cnt, 32'd1024);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mref[i] = '0;
    for (int k = 0; k < 3; k++) begin
      exp_d[k] = '0; exp_v[k] = 0; pend_d[k] = '0; pend_v[k] = 0;
    end

    // Clear after reset, then read back corner addresses.
    cyc(1'b0, 1'b0, 4'h0, 10'd0, 32'd0);
    count_busy("clr_cycles");
    cyc(1'b1, 1'b1, 4'h0, 10'd0, 32'd0);
    chk("rd0", dout0, 32'h0);
    chk("rd0_v", {31'd0, dv0}, 32'd1);
    cyc(1'b1, 1'b1, 4'h0, 10'd511, 32'd0);
    chk("rd511", dout0, 32'h0);
    cyc(1'b1, 1'b1, 4'h0, 10'd1023, 32'd0);
    chk("rd1023", dout0, 32'h0);
    cyc(1'b1, 1'b0, 4'h0, 10'd0, 32'd0);
    chk("rd_pulse", {31'd0, dv0}, 32'd0);

    // Byte lanes.
    cyc(1'b1, 1'b1, 4'hF, 10'h10, 32'hAABBCCDD);
    cyc(1'b1, 1'b1, 4'b0101, 10'h10, 32'h11223344);
    cyc(1'b1, 1'b1, 4'h0, 10'h10, 32'd0);
    chk("lanes", dout0, 32'hAA22CC44);

    // Read-during-write.
    cyc(1'b1, 1'b1, 4'hF, 10'd5, 32'h1);
    cyc(1'b1, 1'b1, 4'h0, 10'd5, 32'd0);
    cyc(1'b1, 1'b1, 4'hF, 10'd5, 32'h2);
    chk("rdw_nc", dout0, 32'h1);
    chk("rdw_nc_v", {31'd0, dv0}, 32'd0);
    chk("rdw_rf", dout1, 32'h1);
    chk("rdw_rf_v", {31'd0, dv1}, 32'd1);
    cyc(1'b1, 1'b0, 4'h0, 10'd0, 32'd0);
    chk("rdw_wf", dout2, 32'h2);
    chk("rdw_wf_v", {31'd0, dv2}, 32'd1);

    // Output register latency with back-to-back reads.
    cyc(1'b1, 1'b1, 4'hF, 10'd1, 32'h11);
    cyc(1'b1, 1'b1, 4'hF, 10'd2, 32'h22);
    cyc(1'b1, 1'b1, 4'hF, 10'd3, 32'h33);
    cyc(1'b1, 1'b1, 4'h0, 10'd1, 32'd0);
    cyc(1'b1, 1'b1, 4'h0, 10'd2, 32'd0);
    chk("or_1", dout2, 32'h11);
    cyc(1'b1, 1'b1, 4'h0, 10'd3, 32'd0);
    chk("or_2", dout2, 32'h22);
    cyc(1'b1, 1'b0, 4'h0, 10'd0, 32'd0);
    chk("or_3", dout2, 32'h33);
    chk("or_3v", {31'd0, dv2}, 32'd1);
    cyc(1'b1, 1'b0, 4'h0, 10'd0, 32'd0);

    // Disabled access must not write.
    cyc(1'b1, 1'b1, 4'hF, 10'd7, 32'h77);
    cyc(1'b1, 1'b1, 4'h0, 10'd7, 32'd0);
    cyc(1'b1, 1'b0, 4'hF, 10'd7, 32'hFFFF_FFFF);
    chk("en0_hold", dout0, 32'h77);
    chk("en0_v", {31'd0, dv0}, 32'd0);
    cyc(1'b1, 1'b1, 4'h0, 10'd7, 32'd0);
    chk("en0_mem", dout0, 32'h77);

    // Randomized traffic on a small address window.
    for (int n = 0; n < 2000; n++) begin
      cyc(1'b1, 1'($urandom_range(0, 3) != 0),
          4'($urandom_range(0, 15)) & {4{1'($urandom_range(0, 1))}},
          10'($urandom_range(0, 15)), $urandom);
    end

    // Reset with a read in flight, then reset again mid-clear.
    cyc(1'b1, 1'b1, 4'h0, 10'd3, 32'd0);
    cyc(1'b0, 1'b0, 4'h0, 10'd0, 32'd0);
    for (int n = 0; n < 300; n++) begin
      cyc(1'b1, 1'b1, 4'hF, 10'($urandom_range(0, 1023)), $urandom);
    end
    cyc(1'b0, 1'b0, 4'h0, 10'd0, 32'd0);
    count_busy("clr_restart");
    for (int i = 0; i < 1024; i++) begin
      cyc(1'b1, 1'b1, 4'h0, 10'(i), 32'd0);
    end
    cyc(1'b1, 1'b0, 4'h0, 10'd0, 32'd0);
    cyc(1'b1, 1'b0, 4'h0, 10'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
